// File: rtl/present_pkg.sv
// Shared constants, FSM encoding and pure helpers for the PRESENT-80 round engine.
package present_pkg;

  localparam int unsigned STATE_W = 64;
  localparam int unsigned KEY_W   = 80;
  localparam int unsigned RC_W    = 5;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_NIB = STATE_W / NIB_W;
  localparam int unsigned RK_LSB  = KEY_W - STATE_W;

  localparam logic [NIB_W-1:0] PRESENT_SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

  // Bit permutation: bit i moves to (16*i) mod 63, bit 63 fixed.
  function automatic logic [STATE_W-1:0] p_layer(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < STATE_W - 1; i++) begin
      p[6'((16 * i) % (STATE_W - 1))] = s[6'(i)];
    end
    p[STATE_W-1] = s[STATE_W-1];
    return p;
  endfunction

  // Key rotation and round-counter injection; the top nibble of the result
  // still needs the S-box, which the caller applies through a present_sbox.
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                   input logic [RC_W-1:0]  rc);
    logic [KEY_W-1:0] r;
    r        = {k[18:0], k[79:19]};
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

endpackage

// File: rtl/present_sbox.sv
// 4-bit PRESENT S-box lookup.
module present_sbox
  import present_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [NIB_W-1:0] nibble_o
);

  assign nibble_o = PRESENT_SBOX[nibble_i];

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT-80 encryption: one round per clock, writing the next
// state back into an external state register.
module present_round_engine
  import present_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 31
) (
  input  logic               inClk,
  input  logic               inRstN,
  input  logic               inStart,
  input  logic [KEY_W-1:0]   inKey,
  input  logic [STATE_W-1:0] inState,
  output logic               outIntWr,
  output logic [STATE_W-1:0] outIntData,
  output logic               outBusy,
  output logic               outDone
);

  fsm_state_e         state_q;
  logic [KEY_W-1:0]   key_q;
  logic [KEY_W-1:0]   key_d;
  logic [RC_W-1:0]    rc_q;
  logic               wr_q;
  logic               busy_q;
  logic               done_q;

  logic [STATE_W-1:0] add_key;
  logic [STATE_W-1:0] sub_out;
  logic [STATE_W-1:0] perm_out;
  logic [KEY_W-1:0]   key_rot;
  logic [NIB_W-1:0]   ks_nib;
  logic [STATE_W-1:0] int_data;

  // Round datapath: add round key, substitute, permute.
  assign add_key = inState ^ key_q[KEY_W-1:RK_LSB];

  for (genvar j = 0; j < NUM_NIB; j++) begin : g_sbox
    present_sbox u_sbox (
      .nibble_i (add_key[NIB_W*j +: NIB_W]),
      .nibble_o (sub_out[NIB_W*j +: NIB_W])
    );
  end

  assign perm_out = p_layer(sub_out);

  // Key schedule: rotate/inject counter, then S-box the top nibble.
  assign key_rot = key_update(key_q, rc_q);

  present_sbox u_ks_sbox (
    .nibble_i (key_rot[KEY_W-1 -: NIB_W]),
    .nibble_o (ks_nib)
  );

  assign key_d = {ks_nib, key_rot[KEY_W-NIB_W-1:0]};

  // Write data select; zero whenever no write is issued.
  always_comb begin
    int_data = '0;
    unique case (state_q)
      ST_ROUND: int_data = perm_out;
      ST_FINAL: int_data = add_key;
      default:  int_data = '0;
    endcase
  end

  assign outIntData = int_data;
  assign outIntWr   = wr_q;
  assign outBusy    = busy_q;
  assign outDone    = done_q;

  // Controller with registered strobes; reset aborts any run in progress.
  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rc_q    <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (inStart) begin
            key_q   <= inKey;
            rc_q    <= RC_W'(1);
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          key_q <= key_d;
          if (rc_q == RC_W'(NUM_ROUNDS)) begin
            state_q <= ST_FINAL;
          end else begin
            rc_q <= rc_q + RC_W'(1);
          end
        end
        ST_FINAL: begin
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_round_engine.sv
// Self-checking bench for present_round_engine with a modelled state register.
module tb_present_round_engine;

  localparam logic [63:0] PT0  = 64'h0;
  localparam logic [63:0] PT1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] K0   = 80'h0;
  localparam logic [79:0] K1   = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CT00 = 64'h5579C1387B228445;
  localparam logic [63:0] CT01 = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT10 = 64'hA112FFC72F68417B;
  localparam logic [63:0] CT11 = 64'h3333DCD3213210D2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [79:0] key;
  logic [63:0] st = '0;
  logic        int_wr;
  logic [63:0] int_data;
  logic        busy;
  logic        done;
  logic        ext_wr;
  logic [63:0] ext_data;

  logic [63:0] exp_q [$];
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  present_round_engine #(.NUM_ROUNDS(31)) dut (
    .inClk      (clk),
    .inRstN     (rst_n),
    .inStart    (start),
    .inKey      (key),
    .inState    (st),
    .outIntWr   (int_wr),
    .outIntData (int_data),
    .outBusy    (busy),
    .outDone    (done)
  );

  // State register: internal write wins over the external port.
  always @(posedge clk) begin
    if (int_wr)      st <= int_data;
    else if (ext_wr) st <= ext_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  // Load plaintext externally and raise start; returns at mid-cycle 1.
  task automatic launch(input logic [63:0] pt, input logic [79:0] k);
    @(negedge clk);
    ext_data = pt;
    ext_wr   = 1'b1;
    key      = k;
    start    = 1'b1;
    @(negedge clk);
    ext_wr   = 1'b0;
  endtask

  // Follow one run from cycle 1 to outDone, then check protocol and ciphertext.
  task automatic track(input bit hold, input int pulse_cyc, input int key_cyc,
                       input logic [79:0] alt_key, input string tag);
    int c;
    int wr_cnt;
    int busy_cnt;
    int busy_bad;
    int zero_bad;
    int done_cyc;
    logic [63:0] expv;
    c = 1; wr_cnt = 0; busy_cnt = 0; busy_bad = 0; zero_bad = 0; done_cyc = 0;
    while (c <= 60) begin
      if (int_wr) wr_cnt++;
      else if (int_data !== 64'h0) zero_bad++;
      if (busy) begin
        busy_cnt++;
        if (c > 32) busy_bad++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      if (!hold) start = (c == pulse_cyc);
      if (c == key_cyc) key = alt_key;
      @(negedge clk);
      c++;
    end
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'd33);
    check({tag, "_wr_pulses"}, 64'(wr_cnt), 64'd32);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
    check({tag, "_idle_data_zero"}, 64'(zero_bad), 64'd0);
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    check({tag, "_ciphertext"}, st, expv);
  endtask

  initial begin
    logic [63:0] held;
    int          wr_seen;

    rst_n = 1'b0; start = 1'b0; key = '0; ext_wr = 1'b0; ext_data = '0;
    repeat (2) @(negedge clk);
    check("rst_wr", 64'(int_wr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", int_data, 64'h0);
    rst_n = 1'b1;

    // Reference vectors
    exp_q.push_back(CT00); launch(PT0, K0); track(1'b0, 0, 0, K0, "v_pt0_k0");
    exp_q.push_back(CT01); launch(PT0, K1); track(1'b0, 0, 0, K0, "v_pt0_k1");
    exp_q.push_back(CT10); launch(PT1, K0); track(1'b0, 0, 0, K0, "v_pt1_k0");
    exp_q.push_back(CT11); launch(PT1, K1); track(1'b0, 0, 0, K0, "v_pt1_k1");

    // Start pulse mid-run is ignored; key change after start has no effect
    exp_q.push_back(CT00); launch(PT0, K0); track(1'b0, 10, 0, K0, "ign_start");
    exp_q.push_back(CT00); launch(PT0, K0); track(1'b0, 0, 1, K1, "key_chg");

    // Reset in cycle 15 aborts the run
    launch(PT0, K0);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_wr", 64'(int_wr), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_data", int_data, 64'h0);
    held  = st;
    rst_n = 1'b1;
    wr_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (int_wr || busy || done) wr_seen++;
    end
    check("abort_no_activity", 64'(wr_seen), 64'd0);
    check("abort_state_held", st, held);

    exp_q.push_back(CT00); launch(PT0, K0); track(1'b0, 0, 0, K0, "post_rst");

    // Back-to-back with start held high; reload state in the IDLE cycle
    exp_q.push_back(CT00); launch(PT0, K0); track(1'b1, 0, 0, K0, "b2b_a");
    @(negedge clk);
    check("b2b_idle_wr", 64'(int_wr), 64'd0);
    check("b2b_idle_busy", 64'(busy), 64'd0);
    ext_data = PT1;
    ext_wr   = 1'b1;
    key      = K0;
    exp_q.push_back(CT10);
    @(negedge clk);
    ext_wr = 1'b0;
    start  = 1'b0;
    track(1'b0, 0, 0, K0, "b2b_b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
